// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with ROB rename state (busy/tag per register)
// Optional feature macro: REGFILE_RENAME_BYPASS_EN (same-cycle commit-to-read bypass)
module regfile_rename #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdEnable,
    input  logic [IDX_W-1:0]  rdIndex1,
    input  logic [IDX_W-1:0]  rdIndex2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    output logic              rdBusy1,
    output logic              rdBusy2,
    output logic [TAG_W-1:0]  rdTag1,
    output logic [TAG_W-1:0]  rdTag2,
    output logic              rdValid,
    input  logic              issueEnable,
    input  logic [IDX_W-1:0]  issueIndex,
    input  logic [TAG_W-1:0]  issueTag,
    input  logic              ROBwriteEnable,
    input  logic [IDX_W-1:0]  ROBwriteIndex,
    input  logic [DATA_W-1:0] ROBwriteData,
    input  logic [TAG_W-1:0]  ROBwriteTag,
    input  logic              flush
);

    logic [DATA_W-1:0] data_q [NUM_REGS];
    logic [DATA_W-1:0] data_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];
    logic [TAG_W-1:0]  tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [DATA_W-1:0] rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
    logic              rd_busy1_q, rd_busy1_d, rd_busy2_q, rd_busy2_d;
    logic [TAG_W-1:0]  rd_tag1_q, rd_tag1_d, rd_tag2_q, rd_tag2_d;
    logic              rd_valid_q, rd_valid_d;

    // Index 0 is never written, so it keeps its reset value of zero/not-busy.
    logic commit_ok, issue_ok;
    assign commit_ok = ROBwriteEnable && (ROBwriteIndex != '0);
    assign issue_ok  = issueEnable && !flush && (issueIndex != '0);

`ifdef REGFILE_RENAME_BYPASS_EN
    // True when this cycle's commit retires the producer a read port is asking about.
    function automatic logic commit_hits(input logic [IDX_W-1:0] idx);
        return commit_ok && (ROBwriteIndex == idx) && busy_q[idx] && (tag_q[idx] == ROBwriteTag);
    endfunction
`endif

    // Next rename state: commit writes data and retires a matching producer; flush or issue then override busy.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (commit_ok) begin
            data_d[ROBwriteIndex] = ROBwriteData;
            if (busy_q[ROBwriteIndex] && (tag_q[ROBwriteIndex] == ROBwriteTag)) begin
                busy_d[ROBwriteIndex] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (issue_ok) begin
            busy_d[issueIndex] = 1'b1;
            tag_d[issueIndex]  = issueTag;
        end
    end

    // Read ports sample the pre-update state; outputs hold while no read is requested.
    always_comb begin
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        rd_busy1_d = rd_busy1_q;
        rd_busy2_d = rd_busy2_q;
        rd_tag1_d  = rd_tag1_q;
        rd_tag2_d  = rd_tag2_q;
        rd_valid_d = rdEnable;
        if (rdEnable) begin
            rd_data1_d = data_q[rdIndex1];
            rd_busy1_d = busy_q[rdIndex1];
            rd_tag1_d  = tag_q[rdIndex1];
            rd_data2_d = data_q[rdIndex2];
            rd_busy2_d = busy_q[rdIndex2];
            rd_tag2_d  = tag_q[rdIndex2];
`ifdef REGFILE_RENAME_BYPASS_EN
            if (commit_hits(rdIndex1)) begin
                rd_data1_d = ROBwriteData;
                rd_busy1_d = 1'b0;
            end
            if (commit_hits(rdIndex2)) begin
                rd_data2_d = ROBwriteData;
                rd_busy2_d = 1'b0;
            end
`endif
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q     <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_busy1_q <= 1'b0;
            rd_busy2_q <= 1'b0;
            rd_tag1_q  <= '0;
            rd_tag2_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_busy1_q <= rd_busy1_d;
            rd_busy2_q <= rd_busy2_d;
            rd_tag1_q  <= rd_tag1_d;
            rd_tag2_q  <= rd_tag2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rdData1 = rd_data1_q;
    assign rdData2 = rd_data2_q;
    assign rdBusy1 = rd_busy1_q;
    assign rdBusy2 = rd_busy2_q;
    assign rdTag1  = rd_tag1_q;
    assign rdTag2  = rd_tag2_q;
    assign rdValid = rd_valid_q;

endmodule
